// File: rtl/screen_mux_sync.sv
// Frame-synchronous priority selector for N screen generators, with optional blank frames
// between screens. Define SCREEN_MUX_FORCE_EN to add the force_en/force_idx override ports.
module screen_mux_sync #(
  parameter int unsigned       N            = 3,
  parameter int unsigned       RGB_W        = 3,
  parameter int unsigned       ADDR_W       = 11,
  parameter logic [RGB_W-1:0]  BG_COLOR     = 3'b001,
  parameter logic [RGB_W-1:0]  BLANK_COLOR  = 3'b000,
  parameter int unsigned       BLANK_FRAMES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [N-1:0]        ce_in,
  input  logic [N*RGB_W-1:0]  rgb_in,
  input  logic [N*ADDR_W-1:0] addr_in,
`ifdef SCREEN_MUX_FORCE_EN
  input  logic                force_en,
  input  logic [2:0]          force_idx,
`endif
  output logic [RGB_W-1:0]    rgb,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [2:0]          sel_idx,
  output logic                sel_valid,
  output logic                busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShow  = 2'd1;
  localparam logic [1:0] StBlank = 2'd2;

  localparam logic [3:0] CntInit = (BLANK_FRAMES == 0) ? 4'd0 : 4'(BLANK_FRAMES - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cur_q, cur_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, busy_q;

  logic              pend_valid;
  logic [2:0]        pend_idx;
  logic              changed;

  // Lowest enabled index wins; a force request overrides the enables entirely.
  always_comb begin
    pend_valid = 1'b0;
    pend_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ce_in[i] && !pend_valid) begin
        pend_valid = 1'b1;
        pend_idx   = 3'(i);
      end
    end
`ifdef SCREEN_MUX_FORCE_EN
    if (force_en) begin
      pend_valid = ({29'd0, force_idx} < N);
      pend_idx   = pend_valid ? force_idx : 3'd0;
    end
`endif
  end

  // cur_q is held at zero outside StShow, so it doubles as the committed index.
  always_comb begin
    changed = (pend_valid != (state_q == StShow)) || (pend_valid && (pend_idx != cur_q));
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    if (frame_start) begin
      case (state_q)
        StBlank: begin
          if (cnt_q == 4'd0) begin
            state_d = pend_valid ? StShow : StIdle;
            cur_d   = pend_valid ? pend_idx : 3'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          if (changed) begin
            if (BLANK_FRAMES == 0) begin
              state_d = pend_valid ? StShow : StIdle;
              cur_d   = pend_valid ? pend_idx : 3'd0;
            end else begin
              state_d = StBlank;
              cur_d   = 3'd0;
              cnt_d   = CntInit;
            end
          end
        end
      endcase
    end
  end

  // Output mux follows the next state so colour and status switch on the same edge.
  always_comb begin
    rgb_d  = BG_COLOR;
    addr_d = '0;
    case (state_d)
      StShow: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (cur_d == 3'(k)) begin
            rgb_d  = rgb_in[k*RGB_W +: RGB_W];
            addr_d = addr_in[k*ADDR_W +: ADDR_W];
          end
        end
      end
      StBlank: rgb_d = BLANK_COLOR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      cnt_q   <= '0;
      rgb_q   <= BG_COLOR;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
      addr_q  <= addr_d;
      valid_q <= (state_d == StShow);
      busy_q  <= (state_d == StBlank);
    end
  end

  assign rgb       = rgb_q;
  assign rom_addr  = addr_q;
  assign sel_idx   = cur_q;
  assign sel_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_screen_mux_sync.sv
// Bench for screen_mux_sync: three instances (BLANK_FRAMES = 0, 1, 2) share one stimulus and
// are checked every cycle against a frame-level model, plus hand-computed literal checks.
module tb_screen_mux_sync;

  logic        clk;
  logic        rst_n;
  logic        fs;
  logic [2:0]  ce;
  logic [8:0]  rgb_in;
  logic [32:0] addr_in;
`ifdef SCREEN_MUX_FORCE_EN
  logic        force_en;
  logic [2:0]  force_idx;
`endif

  logic [2:0]  r0, r1, r2, i0, i1, i2;
  logic [10:0] a0, a1, a2;
  logic        v0, v1, v2, b0, b1, b2;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  screen_mux_sync #(.BLANK_FRAMES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .ce_in(ce), .rgb_in(rgb_in),
    .addr_in(addr_in),
`ifdef SCREEN_MUX_FORCE_EN
    .force_en(force_en), .force_idx(force_idx),
`endif
    .rgb(r0), .rom_addr(a0), .sel_idx(i0), .sel_valid(v0), .busy(b0)
  );

  screen_mux_sync #(.BLANK_FRAMES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .ce_in(ce), .rgb_in(rgb_in),
    .addr_in(addr_in),
`ifdef SCREEN_MUX_FORCE_EN
    .force_en(force_en), .force_idx(force_idx),
`endif
    .rgb(r1), .rom_addr(a1), .sel_idx(i1), .sel_valid(v1), .busy(b1)
  );

  screen_mux_sync #(.BLANK_FRAMES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs), .ce_in(ce), .rgb_in(rgb_in),
    .addr_in(addr_in),
`ifdef SCREEN_MUX_FORCE_EN
    .force_en(force_en), .force_idx(force_idx),
`endif
    .rgb(r2), .rom_addr(a2), .sel_idx(i2), .sel_valid(v2), .busy(b2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed screen (-1 = none), whether a transition is running and how many
  // frame boundaries of it remain. Instance k uses k blank frames.
  int          m_cur   [3];
  bit          m_blank [3];
  int          m_left  [3];
  logic [2:0]  e_rgb   [3];
  logic [10:0] e_addr  [3];
  logic [2:0]  e_idx   [3];
  logic        e_valid [3];
  logic        e_busy  [3];
  bit          model_ok = 0;

  function automatic int pending();
    int p = -1;
`ifdef SCREEN_MUX_FORCE_EN
    if (force_en) return (force_idx < 3) ? int'(force_idx) : -1;
`endif
    for (int i = 2; i >= 0; i--) if (ce[i]) p = i;
    return p;
  endfunction

  always @(posedge clk) begin
    int p;
    p = pending();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_cur[k]   = -1;
        m_blank[k] = 0;
        m_left[k]  = 0;
      end else if (fs) begin
        if (m_blank[k]) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            m_blank[k] = 0;
            m_cur[k]   = p;
          end
        end else if (p != m_cur[k]) begin
          if (k == 0) m_cur[k] = p;
          else begin
            m_blank[k] = 1;
            m_left[k]  = k;
            m_cur[k]   = -1;
          end
        end
      end
      e_busy[k]  = m_blank[k];
      e_valid[k] = !m_blank[k] && (m_cur[k] >= 0);
      e_idx[k]   = e_valid[k] ? 3'(m_cur[k]) : 3'd0;
      e_addr[k]  = 11'd0;
      if (m_blank[k]) e_rgb[k] = 3'b000;
      else if (m_cur[k] < 0) e_rgb[k] = 3'b001;
      else begin
        e_rgb[k]  = rgb_in[m_cur[k]*3 +: 3];
        e_addr[k] = addr_in[m_cur[k]*11 +: 11];
      end
    end
    model_ok = 1;
  end

  task automatic cmp(input int k, input logic [2:0] r, input logic [10:0] a,
                     input logic [2:0] i, input logic v, input logic b);
    check($sformatf("u%0d.rgb", k), 32'(r), 32'(e_rgb[k]));
    check($sformatf("u%0d.rom_addr", k), 32'(a), 32'(e_addr[k]));
    check($sformatf("u%0d.sel_idx", k), 32'(i), 32'(e_idx[k]));
    check($sformatf("u%0d.sel_valid", k), 32'(v), 32'(e_valid[k]));
    check($sformatf("u%0d.busy", k), 32'(b), 32'(e_busy[k]));
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp(0, r0, a0, i0, v0, b0);
      cmp(1, r1, a1, i1, v1, b1);
      cmp(2, r2, a2, i2, v2, b2);
    end
  end

  // Called at a negedge; returns at the negedge after the pulse has been sampled.
  task automatic frame();
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic gap();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    fs      = 1'b0;
    ce      = 3'b000;
    rgb_in  = {3'b110, 3'b101, 3'b011};
    addr_in = {11'h155, 11'h2F0, 11'h0AA};
`ifdef SCREEN_MUX_FORCE_EN
    force_en  = 1'b0;
    force_idx = 3'd0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.rgb", 32'(r0), 32'h1);
    check("idle.addr", 32'(a0), 32'h0);
    check("idle.valid", 32'(v0), 32'h0);
    check("idle.busy", 32'(b2), 32'h0);

    ce = 3'b100;
    repeat (50) @(negedge clk);
    check("nofs.rgb", 32'(r0), 32'h1);
    check("nofs.valid", 32'(v0), 32'h0);

    frame();                                   // F1
    check("f1.u0.rgb", 32'(r0), 32'h6);
    check("f1.u0.addr", 32'(a0), 32'h155);
    check("f1.u0.idx", 32'(i0), 32'h2);
    check("f1.u0.valid", 32'(v0), 32'h1);
    check("f1.u2.busy", 32'(b2), 32'h1);
    check("f1.u2.rgb", 32'(r2), 32'h0);
    gap();
    frame();                                   // F2
    check("f2.u1.idx", 32'(i1), 32'h2);
    check("f2.u2.busy", 32'(b2), 32'h1);
    gap();
    frame();                                   // F3
    check("f3.u2.idx", 32'(i2), 32'h2);
    check("f3.u2.busy", 32'(b2), 32'h0);
    check("f3.u2.rgb", 32'(r2), 32'h6);
    gap();

    ce = 3'b111;
    frame();                                   // F4
    check("f4.u0.idx", 32'(i0), 32'h0);
    check("f4.u0.addr", 32'(a0), 32'h0AA);
    ce = 3'b110;
    rgb_in[2:0] = 3'b111;
    repeat (3) @(negedge clk);
    check("frozen.u0.idx", 32'(i0), 32'h0);
    check("frozen.u0.rgb", 32'(r0), 32'h7);
    frame();                                   // F5
    check("f5.u0.idx", 32'(i0), 32'h1);
    check("f5.u0.rgb", 32'(r0), 32'h5);
    check("f5.u1.idx", 32'(i1), 32'h1);
    check("f5.u2.busy", 32'(b2), 32'h1);
    gap();
    frame();                                   // F6
    check("f6.u2.idx", 32'(i2), 32'h1);
    gap();

    ce = 3'b100;
    for (int f = 0; f < 3; f++) begin          // F7..F9
      frame();
      gap();
    end
    check("f9.u2.idx", 32'(i2), 32'h2);
    ce = 3'b010;
    frame();                                   // F10
    check("f10.u2.busy", 32'(b2), 32'h1);
    check("f10.u2.rgb", 32'(r2), 32'h0);
    gap();
    frame();                                   // F11
    check("f11.u2.busy", 32'(b2), 32'h1);
    gap();
    frame();                                   // F12
    check("f12.u2.idx", 32'(i2), 32'h1);
    check("f12.u2.busy", 32'(b2), 32'h0);
    check("f12.u2.rgb", 32'(r2), 32'h5);
    gap();

    ce = 3'b100;
    for (int f = 0; f < 3; f++) begin          // F13..F15
      frame();
      gap();
    end
    ce = 3'b010;
    frame();                                   // F16
    check("f16.u1.busy", 32'(b1), 32'h1);
    repeat (2) @(negedge clk);
    ce = 3'b001;
    gap();
    frame();                                   // F17
    check("f17.u1.idx", 32'(i1), 32'h0);
    check("f17.u1.valid", 32'(v1), 32'h1);
    check("f17.u1.rgb", 32'(r1), 32'h7);
    check("f17.u2.busy", 32'(b2), 32'h1);
    gap();
    frame();                                   // F18
    check("f18.u2.idx", 32'(i2), 32'h0);
    check("f18.u2.valid", 32'(v2), 32'h1);
    gap();

    ce = 3'b010;
    frame();                                   // F19
    ce = 3'b001;
    gap();
    frame();                                   // F20: back to the pre-blank screen
    check("f20.u1.idx", 32'(i1), 32'h0);
    check("f20.u1.valid", 32'(v1), 32'h1);
    check("f20.u2.busy", 32'(b2), 32'h1);
    gap();
    frame();                                   // F21
    gap();

    ce = 3'b000;
    frame();                                   // F22
    check("f22.u0.valid", 32'(v0), 32'h0);
    check("f22.u0.rgb", 32'(r0), 32'h1);
    check("f22.u2.busy", 32'(b2), 32'h1);
    gap();

    rst_n = 1'b0;                              // reset mid-blank, frame_start ignored
    ce    = 3'b001;
    fs    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    fs    = 1'b0;
    check("rst.u2.rgb", 32'(r2), 32'h1);
    check("rst.u2.busy", 32'(b2), 32'h0);
    check("rst.u2.valid", 32'(v2), 32'h0);
    repeat (3) @(negedge clk);
    check("rst.u0.valid", 32'(v0), 32'h0);
    frame();                                   // F23
    check("f23.u0.idx", 32'(i0), 32'h0);
    check("f23.u0.valid", 32'(v0), 32'h1);
    gap();

`ifdef SCREEN_MUX_FORCE_EN
    force_en  = 1'b1;
    force_idx = 3'd1;
    frame();
    check("force.u0.idx", 32'(i0), 32'h1);
    gap();
    force_idx = 3'd5;
    frame();
    check("force.none.valid", 32'(v0), 32'h0);
    force_en = 1'b0;
    gap();
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
